// File: rtl/x_tdc_accum.sv
// Delay-line sample accumulator: popcount, 2^n-sample sum/min/max/count with selectable result word.
// Optional X_TDC_ACCUM_AVG_EN: select 00 returns the rounded mean instead of the raw sum.
module x_tdc_accum #(
    parameter int p_width    = 32,
    parameter int p_log2_max = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_ctrl,
    input  logic [p_width-1:0] i_sample,
    output logic [31:0]        o_result
);

    localparam int PW = $clog2(p_width + 1);
    localparam int CW = p_log2_max + 1;
    localparam int SW = PW + p_log2_max;
    localparam int NW = $clog2(p_log2_max + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_ACC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [p_width-1:0] r_s1;
    logic [PW-1:0]      r_pc;
    logic [PW-1:0]      w_pc;
    logic               r_start_low;
    logic               r_flush;
    logic [NW-1:0]      r_neff;
    logic [NW-1:0]      w_neff;
    logic [SW-1:0]      r_sum;
    logic [PW-1:0]      r_min;
    logic [PW-1:0]      r_max;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_target;
    logic [CW-1:0]      w_count_inc;
    logic               w_last;
    logic               w_start;
    logic               w_clear;
    logic [1:0]         w_sel;
    logic               w_init;
    logic               w_acc_en;
    logic               w_launch;
    logic               w_busy;
    logic               w_done;
    logic [29:0]        w_val;
    logic               w_unused;

    assign w_clear  = i_ctrl[30];
    assign w_sel    = i_ctrl[9:8];
    assign w_unused = ^{i_ctrl[29:10], i_ctrl[7:5]};

    // History holds "start was low last cycle" and resets to 0, so a start
    // level held through reset must fall and rise again to launch a run.
    assign w_start = i_ctrl[31] & r_start_low;

    assign w_neff = ({27'd0, i_ctrl[4:0]} > 32'(p_log2_max)) ? NW'(p_log2_max)
                                                              : NW'(i_ctrl[4:0]);

    assign w_target    = CW'(1) << r_neff;
    assign w_count_inc = r_count + 1'b1;
    assign w_last      = (w_count_inc == w_target);

    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < p_width; i++) begin
            w_pc = w_pc + PW'(r_s1[i]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1        <= '0;
            r_pc        <= '0;
            r_start_low <= 1'b0;
        end else begin
            r_s1        <= i_sample;
            r_pc        <= w_pc;
            r_start_low <= ~i_ctrl[31];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_acc_en    = 1'b0;
        w_launch    = 1'b0;
        if (w_clear) begin
            w_state_nxt = S_IDLE;
            w_init      = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_init = 1'b1;
                    if (w_start) begin
                        w_state_nxt = S_FLUSH;
                        w_launch    = 1'b1;
                    end
                end
                S_FLUSH: begin
                    w_init = 1'b1;
                    if (r_flush) begin
                        w_state_nxt = S_ACC;
                    end
                end
                S_ACC: begin
                    w_acc_en = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_start) begin
                        w_state_nxt = S_FLUSH;
                        w_launch    = 1'b1;
                        w_init      = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_busy = (r_state == S_FLUSH) || (r_state == S_ACC);
    assign w_done = (r_state == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush <= 1'b0;
            r_neff  <= '0;
        end else begin
            r_flush <= (r_state == S_FLUSH) && (w_state_nxt == S_FLUSH);
            if (w_launch) begin
                r_neff <= w_neff;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum   <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_count <= '0;
        end else if (w_init) begin
            r_sum   <= '0;
            r_min   <= '1;
            r_max   <= '0;
            r_count <= '0;
        end else if (w_acc_en) begin
            r_sum   <= r_sum + SW'(r_pc);
            r_count <= w_count_inc;
            if (r_pc < r_min) begin
                r_min <= r_pc;
            end
            if (r_pc > r_max) begin
                r_max <= r_pc;
            end
        end
    end

`ifdef X_TDC_ACCUM_AVG_EN
    localparam int SW1 = SW + 1;
    logic [SW1-1:0] w_round;
    logic [SW1-1:0] w_mean;

    assign w_round = (r_neff == '0) ? '0 : (SW1'(1) << (r_neff - 1'b1));
    assign w_mean  = ({1'b0, r_sum} + w_round) >> r_neff;
`endif

    always_comb begin
        w_val = '0;
        unique case (w_sel)
`ifdef X_TDC_ACCUM_AVG_EN
            2'b00: w_val = 30'(w_mean);
`else
            2'b00: w_val = 30'(r_sum);
`endif
            2'b01: w_val = (r_count == '0) ? '0 : 30'(r_min);
            2'b10: w_val = 30'(r_max);
            2'b11: w_val = 30'(r_count);
            default: w_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result <= '0;
        end else begin
            o_result <= {w_done, w_busy, w_val};
        end
    end

endmodule
